// File: rtl/btn_debounce_sync.sv
// Button conditioner: two-flop synchronizer, stability-counter debounce, and
// registered single-cycle rise/fall pulses aligned with the committed level.
module btn_debounce_sync #(
  parameter int DEBOUNCE_CYC = 8,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             commit;

  // Stage boundary: synchronized sample vs. committed level
  always_comb begin
    differ = (sync1 != btn_level);
    commit = differ && (cnt == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0     <= 1'b0;
      sync1     <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      sync0    <= btn_in;
      sync1    <= sync0;
      btn_rise <= commit & sync1;
      btn_fall <= commit & ~sync1;
      // Any agreement with the current level restarts the stability window
      if (!differ) begin
        cnt <= '0;
      end else if (commit) begin
        btn_level <= sync1;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Directed bench for btn_debounce_sync: a table of per-cycle vectors plus
// hand-written bounce and reset-interaction sequences.
module tb_btn_debounce_sync;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic  rst;
    logic  btn;
    logic  level;
    logic  rise;
    logic  fall;
    string tag;
  } vec_t;

  vec_t vecs[$];

  btn_debounce_sync #(
    .DEBOUNCE_CYC(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic b, input logic l,
                     input logic ri, input logic f, input string tag, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst = r; v.btn = b; v.level = l; v.rise = ri; v.fall = f;
      v.tag = $sformatf("%s[%0d]", tag, i);
      vecs.push_back(v);
    end
  endtask

  // Drive inputs, take one edge, sample 1 time unit later.
  task automatic step(input logic r, input logic b, input logic l,
                      input logic ri, input logic f, input string tag);
    rst = r;
    btn_in = b;
    @(posedge clk);
    #1;
    chk({tag, ".level"}, btn_level, l);
    chk({tag, ".rise"}, btn_rise, ri);
    chk({tag, ".fall"}, btn_fall, f);
    chk({tag, ".excl"}, btn_rise & btn_fall, 1'b0);
  endtask

  initial begin
    int pat[5] = '{1, 0, 1, 0, 1};
    int rise_cnt;
    int level_edges;
    logic prev_level;
    logic b;

    rst = 1'b1;
    btn_in = 1'b1;

    // Reset with button held high
    add(1, 1, 0, 0, 0, "reset", 2);
    add(0, 0, 0, 0, 0, "idle", 3);
    // Clean press: commit on the 10th edge after btn_in goes high
    add(0, 1, 0, 0, 0, "press_wait", 9);
    add(0, 1, 1, 1, 0, "press_commit", 1);
    add(0, 1, 1, 0, 0, "press_hold", 3);
    // Clean release
    add(0, 0, 1, 0, 0, "rel_wait", 9);
    add(0, 0, 0, 0, 1, "rel_commit", 1);
    add(0, 0, 0, 0, 0, "rel_hold", 3);
    // 5-cycle glitch is rejected
    add(0, 1, 0, 0, 0, "glitch5_hi", 5);
    add(0, 0, 0, 0, 0, "glitch5_lo", 12);
    // 7-cycle glitch (one short of the window) is also rejected
    add(0, 1, 0, 0, 0, "glitch7_hi", 7);
    add(0, 0, 0, 0, 0, "glitch7_lo", 12);

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].btn, vecs[i].level, vecs[i].rise, vecs[i].fall, vecs[i].tag);

    // Bounce 1,0,1,0,1 then hold 1: final rise at row 5, commit at row 14
    rise_cnt = 0;
    level_edges = 0;
    prev_level = btn_level;
    for (int i = 1; i <= 18; i++) begin
      b = (i <= 5) ? logic'(pat[i-1]) : 1'b1;
      step(0, b, (i >= 14), (i == 14), 0, $sformatf("bounce[%0d]", i));
      if (btn_rise) rise_cnt++;
      if (btn_level != prev_level) level_edges++;
      prev_level = btn_level;
    end
    chk("bounce.rise_count", rise_cnt == 1, 1'b1);
    chk("bounce.level_edges", level_edges == 1, 1'b1);

    // Return to level 0
    for (int i = 1; i <= 12; i++)
      step(0, 0, (i < 10), 0, (i == 10), $sformatf("bounce_rel[%0d]", i));

    // Reset mid-count: rst at edge 6, commit 10 edges after deassert
    for (int i = 1; i <= 5; i++)
      step(0, 1, 0, 0, 0, $sformatf("midrst_pre[%0d]", i));
    step(1, 1, 0, 0, 0, "midrst_rst");
    for (int i = 1; i <= 12; i++)
      step(0, 1, (i >= 10), (i == 10), 0, $sformatf("midrst_post[%0d]", i));

    // Reset while level is 1 and button held: level drops, no pulse, re-rises
    step(1, 1, 0, 0, 0, "hirst_rst");
    for (int i = 1; i <= 12; i++)
      step(0, 1, (i >= 10), (i == 10), 0, $sformatf("hirst_post[%0d]", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
